// File: rtl/peribus_pkg.sv
// peribus_pkg: shared FSM states, master count and address field layout for the peripheral bus arbiter.
package peribus_pkg;
   typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;
   localparam int NUM_MASTERS = 2;
   localparam int ADDR_W = 4;
   localparam int PIDX_LSB = 2;
   localparam int PIDX_W = 2;
   localparam int OFS_LSB = 0;
   localparam int OFS_W = 2;
   function automatic logic [PIDX_W-1:0] periph_idx(input logic [ADDR_W-1:0] addr);
      return addr[PIDX_LSB +: PIDX_W];
   endfunction
   function automatic logic [OFS_W-1:0] reg_ofs(input logic [ADDR_W-1:0] addr);
      return addr[OFS_LSB +: OFS_W];
   endfunction
endpackage

// File: rtl/peribus_arbiter_if.sv
// peribus_arbiter_if: master request/ack ports and peripheral strobe/data bus bundled for the arbiter.
interface peribus_arbiter_if
   import peribus_pkg::*;
#(
   parameter int NUM_PERIPH = 4,
   parameter int DATA_W = 16
);
   logic m0_req, m1_req, m0_we, m1_we, m0_ack, m1_ack;
   logic [ADDR_W-1:0] m0_addr, m1_addr;
   logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
   logic [OFS_W-1:0] p_addr;
   logic [DATA_W-1:0] p_write_data;
   logic p_write_en, p_read_en;
   logic [NUM_PERIPH-1:0] p_chipselect;
   logic [NUM_PERIPH*DATA_W-1:0] p_read_data;
   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, p_read_data,
      output m0_ack, m1_ack, m0_rdata, m1_rdata, p_addr, p_write_data, p_write_en, p_read_en, p_chipselect
   );
   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, p_read_data,
      input  m0_ack, m1_ack, m0_rdata, m1_rdata, p_addr, p_write_data, p_write_en, p_read_en, p_chipselect
   );
endinterface

// File: rtl/peribus_arbiter_rr_arbiter.sv
// rr_arbiter: 2-way round-robin picker; on contention the master not granted last wins.
module rr_arbiter
   import peribus_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   last,
   output logic [NUM_MASTERS-1:0] grant
);
   always_comb grant = {req[1] & (!req[0] | !last), req[0] & (!req[1] | last)};
endmodule

// File: rtl/peribus_arbiter.sv
// peribus_arbiter: two masters share one peripheral bus through an IDLE/XFER/ACK FSM.
// Every output is a register; the peripheral strobes exist only during the single XFER cycle.
module peribus_arbiter
   import peribus_pkg::*;
#(
   parameter int NUM_PERIPH = 4,
   parameter int DATA_W = 16
)(
   input logic clock,
   input logic reset_n,
   peribus_arbiter_if.slave bus
);
   state_t state;
   logic last, owner;
   logic [PIDX_W-1:0] pidx;
   logic [NUM_MASTERS-1:0] grant;
   logic we_w;
   logic [ADDR_W-1:0] addr_w;
   logic [DATA_W-1:0] wdata_w;
   logic [DATA_W-1:0] rd [NUM_PERIPH];
   rr_arbiter u_rr (.req({bus.m1_req, bus.m0_req}), .last(last), .grant(grant));
   assign we_w = grant[1] ? bus.m1_we : bus.m0_we;
   assign addr_w = grant[1] ? bus.m1_addr : bus.m0_addr;
   assign wdata_w = grant[1] ? bus.m1_wdata : bus.m0_wdata;
   for (genvar i = 0; i < NUM_PERIPH; i++) begin : g_rd
      assign rd[i] = bus.p_read_data[i*DATA_W +: DATA_W];
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         last <= 1'b1;
         owner <= 1'b0;
         pidx <= '0;
         bus.m0_ack <= 1'b0;
         bus.m1_ack <= 1'b0;
         bus.m0_rdata <= '0;
         bus.m1_rdata <= '0;
         bus.p_chipselect <= '0;
         bus.p_addr <= '0;
         bus.p_write_en <= 1'b0;
         bus.p_read_en <= 1'b0;
         bus.p_write_data <= '0;
      end else
         case (state)
            IDLE:
               if (|grant) begin
                  state <= XFER;
                  last <= grant[1];
                  owner <= grant[1];
                  pidx <= periph_idx(addr_w);
                  bus.p_chipselect <= NUM_PERIPH'(1) << periph_idx(addr_w);
                  bus.p_addr <= reg_ofs(addr_w);
                  bus.p_write_en <= we_w;
                  bus.p_read_en <= !we_w;
                  bus.p_write_data <= wdata_w;
               end
            XFER: begin
               state <= ACK;
               bus.m0_ack <= !owner;
               bus.m1_ack <= owner;
               // read data is captured on the same edge that drops the strobes
               if (bus.p_read_en && !owner) bus.m0_rdata <= rd[pidx];
               if (bus.p_read_en && owner) bus.m1_rdata <= rd[pidx];
               bus.p_chipselect <= '0;
               bus.p_addr <= '0;
               bus.p_write_en <= 1'b0;
               bus.p_read_en <= 1'b0;
               bus.p_write_data <= '0;
            end
            default: begin
               state <= IDLE;
               bus.m0_ack <= 1'b0;
               bus.m1_ack <= 1'b0;
            end
         endcase
endmodule

// File: tb/tb_peribus_arbiter.sv
// tb_peribus_arbiter: directed table, corner-case sequences and random traffic against a transaction-level model.
module tb_peribus_arbiter;
   import peribus_pkg::*;
   localparam int NP = 4;
   localparam int DW = 16;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;
   peribus_arbiter_if #(.NUM_PERIPH(NP), .DATA_W(DW)) bus();
   peribus_arbiter #(.NUM_PERIPH(NP), .DATA_W(DW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
   logic [DW-1:0] pmem [NP];
   assign bus.p_read_data = {pmem[3], pmem[2], pmem[1], pmem[0]};
   int checks = 0, errors = 0, cyc = 0;
   // reference: a bus transaction occupies three edges from acceptance to the next sampling point
   int phase = 0;
   bit mlast = 1'b1, mown = 1'b0, mwe = 1'b0;
   logic [3:0] maddr = '0;
   logic [DW-1:0] mwd = '0;
   logic [DW-1:0] mrd [2] = '{default: '0};
   typedef struct {
      int m; bit we; logic [3:0] addr; logic [DW-1:0] wd; logic [DW-1:0] pd;
      logic [NP-1:0] cs; logic [1:0] pa; logic [DW-1:0] rd0; logic [DW-1:0] rd1;
   } vec_t;
   vec_t tbl [6];
   bit act [2];

   task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act_v, exp_v);
      end
   endtask

   task automatic model_edge();
      if (phase == 1) begin
         if (!mwe) mrd[mown] = pmem[maddr[3:2]];
         phase = 2;
      end else if (phase == 2) phase = 0;
      else if (bus.m0_req || bus.m1_req) begin
         mown = (bus.m0_req && bus.m1_req) ? !mlast : bus.m1_req;
         mlast = mown;
         mwe = mown ? bus.m1_we : bus.m0_we;
         maddr = mown ? bus.m1_addr : bus.m0_addr;
         mwd = mown ? bus.m1_wdata : bus.m0_wdata;
         phase = 1;
      end
   endtask

   task automatic check_outputs();
      logic xf, ak;
      logic [NP-1:0] cs;
      xf = (phase == 1);
      ak = (phase == 2);
      cs = xf ? (NP'(1) << maddr[3:2]) : '0;
      chk("p_chipselect", 64'(bus.p_chipselect), 64'(cs));
      chk("p_addr", 64'(bus.p_addr), 64'(xf ? maddr[1:0] : 2'd0));
      chk("p_write_en", 64'(bus.p_write_en), 64'(xf & mwe));
      chk("p_read_en", 64'(bus.p_read_en), 64'(xf & !mwe));
      chk("p_write_data", 64'(bus.p_write_data), 64'(xf ? mwd : '0));
      chk("m0_ack", 64'(bus.m0_ack), 64'(ak & !mown));
      chk("m1_ack", 64'(bus.m1_ack), 64'(ak & mown));
      chk("m0_rdata", 64'(bus.m0_rdata), 64'(mrd[0]));
      chk("m1_rdata", 64'(bus.m1_rdata), 64'(mrd[1]));
   endtask

   task automatic tick();
      @(posedge clock);
      cyc++;
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic set_m(input int m, input bit r, input bit w, input logic [3:0] a, input logic [DW-1:0] d);
      if (m == 0) begin
         bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   task automatic new_txn(input int m);
      set_m(m, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom));
      act[m] = 1'b1;
   endtask

   task automatic do_reset();
      set_m(0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0);
      act[0] = 1'b0;
      act[1] = 1'b0;
      reset_n = 1'b0;
      phase = 0;
      mlast = 1'b1;
      mrd[0] = '0;
      mrd[1] = '0;
      #1;
      check_outputs();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int got, last_cyc, waited, n;
      for (int i = 0; i < NP; i++) pmem[i] = '0;
      set_m(0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0);
      tbl[0] = '{0, 1'b1, 4'h1, 16'h00FF, 16'h0000, 4'b0001, 2'd1, 16'h0000, 16'h0000};
      tbl[1] = '{1, 1'b0, 4'hE, 16'h0000, 16'hBEEF, 4'b1000, 2'd2, 16'h0000, 16'hBEEF};
      tbl[2] = '{0, 1'b0, 4'h5, 16'h3C3C, 16'h1234, 4'b0010, 2'd1, 16'h1234, 16'hBEEF};
      tbl[3] = '{1, 1'b1, 4'hB, 16'hA5A5, 16'h9999, 4'b0100, 2'd3, 16'h1234, 16'hBEEF};
      tbl[4] = '{0, 1'b0, 4'h8, 16'h0001, 16'h0F0F, 4'b0100, 2'd0, 16'h0F0F, 16'hBEEF};
      tbl[5] = '{1, 1'b0, 4'h3, 16'h0000, 16'hCAFE, 4'b0001, 2'd3, 16'h0F0F, 16'hCAFE};
      do_reset();
      chk("reset_last_grant_m0_first", 64'(bus.m0_rdata | bus.m1_rdata), 64'(0));
      for (int v = 0; v < 6; v++) begin
         pmem[tbl[v].addr[3:2]] = tbl[v].pd;
         set_m(tbl[v].m, 1'b1, tbl[v].we, tbl[v].addr, tbl[v].wd);
         tick();
         chk("tbl_cs", 64'(bus.p_chipselect), 64'(tbl[v].cs));
         chk("tbl_paddr", 64'(bus.p_addr), 64'(tbl[v].pa));
         chk("tbl_we", 64'(bus.p_write_en), 64'(tbl[v].we));
         chk("tbl_re", 64'(bus.p_read_en), 64'(!tbl[v].we));
         chk("tbl_wdata", 64'(bus.p_write_data), 64'(tbl[v].wd));
         tick();
         chk("tbl_ack", 64'({bus.m1_ack, bus.m0_ack}), 64'(tbl[v].m == 1 ? 2'b10 : 2'b01));
         chk("tbl_rd0", 64'(bus.m0_rdata), 64'(tbl[v].rd0));
         chk("tbl_rd1", 64'(bus.m1_rdata), 64'(tbl[v].rd1));
         set_m(tbl[v].m, 0, 0, 0, 0);
         tick();
      end
      // continuous contention from reset: strict alternation starting with m0
      do_reset();
      set_m(0, 1'b1, 1'b1, 4'h3, 16'hAAAA);
      set_m(1, 1'b1, 1'b1, 4'hC, 16'h5555);
      got = 0;
      last_cyc = 0;
      waited = 0;
      while (got < 6 && waited < 40) begin
         tick();
         waited++;
         chk("both_ack", 64'(bus.m0_ack & bus.m1_ack), 64'(0));
         if (bus.m0_ack || bus.m1_ack) begin
            chk("rr_order", 64'(bus.m1_ack), 64'(got % 2));
            if (got > 0) chk("ack_spacing", 64'(cyc - last_cyc), 64'(3));
            last_cyc = cyc;
            got++;
         end
      end
      chk("contention_count", 64'(got), 64'(6));
      set_m(0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0);
      repeat (3) tick();
      // m1 abandons req during XFER; the transfer still completes once
      pmem[1] = 16'h7777;
      set_m(1, 1'b1, 1'b0, 4'h4, 16'h0000);
      tick();
      chk("drop_cs", 64'(bus.p_chipselect), 64'(4'b0010));
      set_m(1, 0, 0, 0, 0);
      n = 0;
      repeat (5) begin
         tick();
         n += int'(bus.m1_ack);
      end
      chk("drop_ack_count", 64'(n), 64'(1));
      chk("drop_rdata", 64'(bus.m1_rdata), 64'(16'h7777));
      // reset in the middle of an m0 write XFER discards it
      set_m(0, 1'b1, 1'b1, 4'h2, 16'h1111);
      tick();
      chk("rst_xfer_pre_we", 64'(bus.p_write_en), 64'(1));
      #2;
      do_reset();
      n = 0;
      repeat (6) begin
         tick();
         n += int'(bus.m0_ack) + int'(bus.p_write_en);
      end
      chk("rst_xfer_no_ack_or_we", 64'(n), 64'(0));
      // reset during ACK drops the ack
      set_m(1, 1'b1, 1'b0, 4'h0, 16'h0000);
      tick();
      tick();
      chk("rst_ack_pre", 64'(bus.m1_ack), 64'(1));
      #2;
      do_reset();
      chk("rst_ack_post", 64'(bus.m1_ack), 64'(0));
      // random traffic
      for (int k = 0; k < 3000; k++) begin
         tick();
         pmem[$urandom_range(0, NP-1)] = DW'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
            continue;
         end
         for (int m = 0; m < 2; m++) begin
            if (act[m] && (m == 1 ? bus.m1_ack : bus.m0_ack)) begin
               act[m] = 1'b0;
               if ($urandom_range(0, 1) == 1) new_txn(m);
               else set_m(m, 0, 0, 0, 0);
            end else if (!act[m] && $urandom_range(0, 2) == 0) new_txn(m);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
